// File: rtl/int_ctrl.sv
// int_ctrl: 8-line interrupt controller with a small CPU register window.
//
// Each raw INT line is synchronised (s1, s2) and edge-detected (s3). Per-line
// MODE selects rising-edge capture into PEND (sticky, write-1-to-clear) or
// level tracking (PEND follows the synchronised line). Enabled pending lines
// form the active vector; fixed priority (line 0 highest) picks the id, and a
// registered one-hot of that id drives Interrupts.
//
// Ports:
//   clk        system clock (CPU bus clock)
//   rst_n      asynchronous reset, active-low
//   INT[7:0]   raw interrupt lines, asynchronous to clk
//   CS         chip select
//   adresse    register select: 0 PEND, 1 EN, 2 MODE, 3 STATUS
//   write      CPU write strobe (qualified by CS)
//   data_w     CPU write data; only [7:0] are used
//   data_r     combinational read data, 0 when CS=0
//   Interrupts registered one-hot request to the CPU
module int_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  INT,
  input  logic        CS,
  input  logic [1:0]  adresse,
  input  logic        write,
  input  logic [15:0] data_w,
  output logic [15:0] data_r,
  output logic [7:0]  Interrupts
);

  logic [7:0] s1_q, s2_q, s3_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] en_q, en_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] irq_q, irq_d;

  logic [7:0] wdat;
  logic       wr_pend, wr_en, wr_mode, wr_stat;
  logic [7:0] edge_det;
  logic [7:0] act;
  logic       valid;
  logic [2:0] id;

  // Upper write-data byte carries no register bits.
  logic unused_data_hi;
  assign unused_data_hi = ^data_w[15:8];

  assign wdat     = data_w[7:0];
  assign wr_pend  = CS && write && (adresse == 2'd0);
  assign wr_en    = CS && write && (adresse == 2'd1);
  assign wr_mode  = CS && write && (adresse == 2'd2);
  assign wr_stat  = CS && write && (adresse == 2'd3);
  assign edge_det = s2_q & ~s3_q;

  always_comb begin
    en_d   = wr_en   ? wdat : en_q;
    mode_d = wr_mode ? wdat : mode_q;
    pend_d = pend_q;
    for (int i = 0; i < 8; i++) begin
      if (wr_mode && wdat[i] && !mode_q[i]) begin
        // Switching into edge mode discards stale level state; a coincident
        // edge still counts.
        pend_d[i] = edge_det[i];
      end else if (!mode_q[i]) begin
        pend_d[i] = s2_q[i];
      end else begin
        // Set (edge or software) has priority over write-1-to-clear.
        pend_d[i] = edge_det[i] | (wr_stat & wdat[i]) |
                    (pend_q[i] & ~(wr_pend & wdat[i]));
      end
    end
  end

  assign act   = pend_q & en_q;
  assign valid = |act;

  always_comb begin
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) begin
        id = 3'(i);
      end
    end
  end

  assign irq_d = valid ? (8'h01 << id) : 8'h00;

  always_comb begin
    data_r = 16'h0000;
    if (CS) begin
      unique case (adresse)
        2'd0: data_r = {8'h00, pend_q};
        2'd1: data_r = {8'h00, en_q};
        2'd2: data_r = {8'h00, mode_q};
        2'd3: data_r = {valid, 12'h000, id};
        default: data_r = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 8'h00;
      s2_q   <= 8'h00;
      s3_q   <= 8'h00;
      pend_q <= 8'h00;
      en_q   <= 8'h00;
      mode_q <= 8'h00;
      irq_q  <= 8'h00;
    end else begin
      s1_q   <= INT;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      irq_q  <= irq_d;
    end
  end

  assign Interrupts = irq_q;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock (the CPU bus clock)
- rst_n  in  1  asynchronous reset, active-low
- INT  in  8  raw external interrupt lines, asynchronous to clk
- CS  in  1  chip select, high when CPU address[15:14] = 2'b10
- adresse  in  2  register select (CPU address[1:0])
- write  in  1  CPU write strobe
- data_w  in  16  CPU write data
- data_r  out  16  read data to CPU bus
- Interrupts  out  8  one-hot active request to CPU Interrupts port

REQ-002 The block SHALL have one clock and one reset only: clk, and rst_n (asynchronous, active-low).

Function
REQ-003 Each INT line SHALL pass through a 2-flop synchronizer (s1, s2), then a third flop s3 for edge detection.
REQ-004 The block SHALL hold four 8-bit registers, with bit i mapping to line i:
- adresse 0: PEND (read; write-1-to-clear)
- adresse 1: EN (read/write)
- adresse 2: MODE (read/write; 1 = rising-edge, 0 = level)
- adresse 3: STATUS (read: {bit15 valid, bits2:0 id}; write: software set of PEND)
REQ-005 A register write SHALL occur on the rising clk edge when CS=1 and write=1, using data_w[7:0]; data_w[15:8] SHALL be ignored.
REQ-006 Reads SHALL be combinational from the addressed register, with upper bits zero except STATUS bit15.
REQ-007 data_r SHALL be 16'h0000 when CS=0.
REQ-008 In edge mode, PEND[i] SHALL set on the clock edge where s2[i]=1 and s3[i]=0.
REQ-009 In edge mode, PEND[i] SHALL clear only by a PEND write with data_w[i]=1.
REQ-010 If a set and a clear of PEND[i] occur in the same cycle, the set SHALL win.
REQ-011 In level mode, PEND[i] SHALL be loaded every cycle with s2[i]; W1C and software set SHALL have no effect on it.
REQ-012 A STATUS write SHALL set PEND[i] for every bit with data_w[i]=1 and MODE[i]=1.
REQ-013 A MODE write that changes bit i from 0 to 1 SHALL clear PEND[i] in the same cycle; an edge coincident with that write SHALL still set PEND[i].
REQ-014 The active vector SHALL be act = PEND & EN.
REQ-015 Priority SHALL be fixed, with line 0 highest.
REQ-016 id SHALL be the index of the lowest set bit of act; valid SHALL equal |act.
REQ-017 STATUS read SHALL reflect the current act combinationally.
REQ-018 Interrupts SHALL be a registered one-hot of id when valid, else 8'h00, updated on every clk edge from the current act.
REQ-019 Latency SHALL be as follows: an edge-mode INT rising before clk edge k gives s2=1 after edge k+1, PEND=1 after edge k+2, and Interrupts asserted after edge k+3.
REQ-020 After a W1C at edge m, Interrupts SHALL drop, or move to the next-priority line, after edge m+1.
REQ-021 Clearing EN[i] SHALL remove line i from act immediately and from Interrupts after the next edge; PEND[i] SHALL be retained.
REQ-022 Lines with EN=0 SHALL still latch PEND.
REQ-023 Pulses shorter than one clk period MAY be missed; no other loss SHALL occur. A second edge while PEND[i]=1 SHALL be absorbed, with no counting.

Reset
REQ-024 On rst_n=0, the following SHALL be asynchronously cleared to 0: s1, s2, s3, PEND, EN, MODE and Interrupts.
REQ-025 While rst_n=0, data_r SHALL read 0 for all registers, and writes SHALL be ignored.
REQ-026 An edge-mode line held high through reset release SHALL register one rising edge, about 3 edges after release.
REQ-027 Reset asserted mid-operation SHALL clear pending state with no residual request on Interrupts in the following cycle.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Edge latency: MODE=8'h01, EN=8'h01, INT[0] 0->1 before edge k -> PEND=8'h01 after k+2; Interrupts=8'h01 after k+3; STATUS=16'h8000.
- Priority and W1C: PEND set on lines 5 and 2, EN=8'hFF -> Interrupts=8'h04, STATUS=16'h8002; write PEND=8'h04 -> Interrupts=8'h20 next edge; write 8'h20 -> 8'h00.
- Level mode: MODE=0, EN=8'h80, hold INT[7]=1 -> Interrupts=8'h80; W1C PEND=8'h80 has no effect; INT[7]=0 -> Interrupts=8'h00 after 3 edges.
- Set-wins collision: edge on line 3 detected in the same cycle as W1C of bit 3 -> PEND[3] stays 1.
- Masking and software set: EN=0, STATUS write 8'h10 with MODE=8'h10 -> PEND=8'h10, Interrupts=0; EN=8'h10 -> Interrupts=8'h10 after next edge.
- Reset mid-operation: Interrupts=8'h01 active, pulse rst_n low asynchronously -> Interrupts, PEND, EN and MODE read 0 immediately; data_r=0.
